// File: rtl/llc_writeback_engine.sv
// LLC writeback engine: queues dirty victims and issues one bus writeback
// per entry, rebuilding the line address from {tag, index}.
module llc_writeback_engine #(
  parameter int ADDR_SIZE   = 32,
  parameter int INDEX_SIZE  = 14,
  parameter int TAG_SIZE    = 12,
  parameter int OFFSET_SIZE = 6,
  parameter int FIFO_DEPTH  = 4,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  victim_valid,
  output logic                  victim_ready,
  input  logic [TAG_SIZE-1:0]   victim_tag,
  input  logic [INDEX_SIZE-1:0] victim_index,
  input  logic                  victim_dirty,
  output logic                  bus_req,
  output logic [ADDR_SIZE-1:0]  bus_addr,
  input  logic                  bus_ack,
  output logic                  busy,
  output logic [CNT_W-1:0]      wb_count,
  output logic [CNT_W-1:0]      clean_drops
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_F = PTR_W + 1;
  localparam int ENT_W = TAG_SIZE + INDEX_SIZE;

  typedef enum logic {IDLE, REQ} state_t;

  state_t           state;
  logic [ENT_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [CNT_F-1:0] count;

  logic full;
  logic empty;
  logic take;
  logic push;
  logic pop;
  logic drop;

  assign full  = (count == CNT_F'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign victim_ready = !full;

  // ready depends only on the registered count, so a pop never frees a slot
  // for a push in the same cycle
  assign take = victim_valid && victim_ready;
  assign push = take && victim_dirty;
  assign drop = take && !victim_dirty;
  assign pop  = (state == REQ) && bus_ack;

  assign busy = !empty || (state != IDLE);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= {victim_tag, victim_index};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + PTR_W'(1);
      end
      if (pop) begin
        rptr <= rptr + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CNT_F'(1);
        2'b01:   count <= count - CNT_F'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      bus_req  <= 1'b0;
      bus_addr <= '0;
      wb_count <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!empty) begin
            state    <= REQ;
            bus_req  <= 1'b1;
            bus_addr <= {mem[rptr], {OFFSET_SIZE{1'b0}}};
          end
        end
        REQ: begin
          if (bus_ack) begin
            state   <= IDLE;
            bus_req <= 1'b0;
            if (wb_count != '1) begin
              wb_count <= wb_count + CNT_W'(1);
            end
          end
        end
        default: begin
          state   <= IDLE;
          bus_req <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clean_drops <= '0;
    end else if (drop && (clean_drops != '1)) begin
      clean_drops <= clean_drops + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_llc_writeback_engine.sv
// Bench for llc_writeback_engine: directed scenarios plus random traffic,
// checked by a queue-based reference model and a negedge monitor.
module tb_llc_writeback_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        victim_valid;
  logic        victim_ready;
  logic [11:0] victim_tag;
  logic [13:0] victim_index;
  logic        victim_dirty;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic        bus_ack;
  logic        busy;
  logic [15:0] wb_count;
  logic [15:0] clean_drops;

  int n_chk  = 0;
  int n_fail = 0;

  // reference model: pending line addresses in arrival order
  logic [31:0] q[$];
  int          m_wb = 0;
  int          m_cd = 0;

  llc_writeback_engine dut (
    .clk          (clk),
    .rst          (rst),
    .victim_valid (victim_valid),
    .victim_ready (victim_ready),
    .victim_tag   (victim_tag),
    .victim_index (victim_index),
    .victim_dirty (victim_dirty),
    .bus_req      (bus_req),
    .bus_addr     (bus_addr),
    .bus_ack      (bus_ack),
    .busy         (busy),
    .wb_count     (wb_count),
    .clean_drops  (clean_drops)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] line_addr(int tag, int idx);
    return 32'(tag * (1 << 20) + idx * (1 << 6));
  endfunction

  function automatic int sat(int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      m_wb = 0;
      m_cd = 0;
    end else begin
      int sz;
      sz = q.size();
      chk("ready", 32'(victim_ready), 32'(sz < 4));
      chk("busy", 32'(busy), 32'(sz != 0));
      chk("wb_count", 32'(wb_count), 32'(m_wb));
      chk("clean_drops", 32'(clean_drops), 32'(m_cd));
      if (bus_req) begin
        if (sz == 0) chk("req_empty", 32'(bus_req), 32'd0);
        else chk("bus_addr", bus_addr, q[0]);
      end
      if (bus_req && bus_ack && sz != 0) begin
        void'(q.pop_front());
        m_wb = sat(m_wb);
      end
      if (victim_valid && sz < 4) begin
        if (victim_dirty)
          q.push_back(line_addr(int'(victim_tag), int'(victim_index)));
        else
          m_cd = sat(m_cd);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_v(logic v, logic d, int tag, int idx);
    victim_valid = v;
    victim_dirty = d;
    victim_tag   = 12'(tag);
    victim_index = 14'(idx);
  endtask

  task automatic wait_req();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus_req) return;
      cyc();
    end
    chk("req_timeout", 32'd0, 32'd1);
  endtask

  task automatic ack_one();
    wait_req();
    cyc();
    bus_ack = 1'b1;
    @(negedge clk);
    cyc();
    bus_ack = 1'b0;
  endtask

  initial begin
    int w;
    rst = 1'b1;
    bus_ack = 1'b0;
    set_v(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(victim_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req", 32'(bus_req), 32'd0);
    chk("rst_addr", bus_addr, 32'd0);

    // single dirty victim, exact latency
    cyc();
    set_v(1, 1, 'hABC, 'h1234);
    cyc();
    set_v(0, 0, 0, 0);
    @(negedge clk);
    chk("t2_req_c1", 32'(bus_req), 32'd0);
    cyc();
    @(negedge clk);
    chk("t2_req_c2", 32'(bus_req), 32'd1);
    chk("t2_addr_c2", bus_addr, 32'hABC48D00);
    cyc();
    @(negedge clk);
    chk("t2_req_c3", 32'(bus_req), 32'd1);
    cyc();
    bus_ack = 1'b1;
    @(negedge clk);
    chk("t2_req_c4", 32'(bus_req), 32'd1);
    cyc();
    bus_ack = 1'b0;
    @(negedge clk);
    chk("t2_req_c5", 32'(bus_req), 32'd0);
    chk("t2_busy_c5", 32'(busy), 32'd0);
    chk("t2_wb_c5", 32'(wb_count), 32'd1);

    // clean victim
    cyc();
    set_v(1, 0, 'h123, 'h0456);
    cyc();
    set_v(0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t3_no_req", 32'(bus_req), 32'd0);
      cyc();
    end
    @(negedge clk);
    chk("t3_drops", 32'(clean_drops), 32'd1);
    chk("t3_busy", 32'(busy), 32'd0);

    // fill past capacity, then drain
    cyc();
    for (int i = 0; i < 5; i++) begin
      set_v(1, 1, int'($urandom_range(0, 4095)),
            int'($urandom_range(0, 16383)));
      @(negedge clk);
      chk("t4_ready", 32'(victim_ready), 32'(i < 4));
      cyc();
    end
    set_v(0, 0, 0, 0);
    wait_req();
    cyc();
    bus_ack = 1'b1;
    @(negedge clk);
    cyc();
    bus_ack = 1'b0;
    @(negedge clk);
    chk("t4_ready_pop", 32'(victim_ready), 32'd1);
    chk("t4_bubble", 32'(bus_req), 32'd0);
    cyc();
    @(negedge clk);
    chk("t4_next_req", 32'(bus_req), 32'd1);
    for (int i = 0; i < 3; i++) ack_one();
    @(negedge clk);
    chk("t4_wb", 32'(wb_count), 32'd5);
    chk("t4_idle", 32'(busy), 32'd0);

    // push in the same cycle as an ack
    cyc();
    for (int i = 0; i < 2; i++) begin
      set_v(1, 1, 'h100 + i, 'h200 + i);
      cyc();
    end
    set_v(0, 0, 0, 0);
    wait_req();
    cyc();
    bus_ack = 1'b1;
    set_v(1, 1, 'hFED, 'h3210);
    @(negedge clk);
    cyc();
    bus_ack = 1'b0;
    set_v(0, 0, 0, 0);
    for (int i = 0; i < 2; i++) ack_one();
    @(negedge clk);
    chk("t5_wb", 32'(wb_count), 32'd8);
    chk("t5_idle", 32'(busy), 32'd0);

    // long stall, then spurious acks while idle
    cyc();
    set_v(1, 1, 'h5A5, 'h2A2A);
    cyc();
    set_v(0, 0, 0, 0);
    wait_req();
    for (int i = 0; i < 20; i++) begin
      cyc();
      @(negedge clk);
      chk("t6_stable", bus_addr, line_addr('h5A5, 'h2A2A));
      chk("t6_held", 32'(bus_req), 32'd1);
    end
    cyc();
    bus_ack = 1'b1;
    @(negedge clk);
    cyc();
    w = m_wb;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_spurious", 32'(wb_count), 32'(w));
      cyc();
    end
    bus_ack = 1'b0;

    // reset while a request is outstanding
    for (int i = 0; i < 3; i++) begin
      set_v(1, 1, 'h300 + i, 'h100 + i);
      cyc();
    end
    set_v(0, 0, 0, 0);
    wait_req();
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("t1_req", 32'(bus_req), 32'd0);
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_wb", 32'(wb_count), 32'd0);
    chk("t1_drops", 32'(clean_drops), 32'd0);
    chk("t1_ready", 32'(victim_ready), 32'd1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      cyc();
      set_v(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 3) != 0),
            int'($urandom_range(0, 4095)), int'($urandom_range(0, 16383)));
      bus_ack = logic'($urandom_range(0, 2) == 0);
    end
    cyc();
    set_v(0, 0, 0, 0);
    bus_ack = 1'b1;
    repeat (20) cyc();
    @(negedge clk);
    chk("drain_busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
